// File: rtl/rr_switch_core.sv
// N-port valid/ready switch core: per-input FIFOs, table-driven destination lookup,
// per-output round-robin arbiters with registered outputs, and a windowed activity counter.
module rr_switch_core #(
  parameter int ROUTERID = -1,
  parameter int PORTS = 5,
  parameter int PORT_W = 3,
  parameter int ADDR_W = 4,
  parameter int PAYLOAD_W = 16,
  parameter int DEPTH = 4,
  parameter logic [(2**ADDR_W)*PORT_W-1:0] ROUTE_TABLE = '0,
  parameter int WINDOW_LOG2 = 10,
  parameter int CNT_W = 20,
  localparam int FLIT_W = ADDR_W + PAYLOAD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PORTS-1:0]         in_valid,
  output logic [PORTS-1:0]         in_ready,
  input  logic [PORTS*FLIT_W-1:0]  in_flit,
  output logic [PORTS-1:0]         out_valid,
  input  logic [PORTS-1:0]         out_ready,
  output logic [PORTS*FLIT_W-1:0]  out_flit,
  output logic [PORTS-1:0]         drop,
  output logic [CNT_W-1:0]         flit_count,
  output logic                     count_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam bit CFG_OK = (PORTS >= 2) && (PORTS <= 8) && ((1 << PORT_W) >= PORTS) &&
                          (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) && (ROUTERID >= -1);

  if (!CFG_OK) begin : g_cfg_err
    $error("rr_switch_core: illegal parameter set");
  end

  logic [FLIT_W-1:0]  mem [PORTS][DEPTH];
  logic [AW:0]        wr_ptr [PORTS];
  logic [AW:0]        rd_ptr [PORTS];
  logic [FLIT_W-1:0]  head [PORTS];
  logic [PORT_W-1:0]  route [PORTS];
  logic [PORT_W-1:0]  rr_ptr [PORTS];
  int                 winner [PORTS];
  logic [PORTS-1:0]   empty, full, legal, push, pop, grant;
  logic [WINDOW_LOG2-1:0] sampler;
  logic [CNT_W-1:0]   running, running_sat;
  logic [CNT_W:0]     running_sum;
  logic [3:0]         acc;

  // FIFO status, head lookup and illegal-route discard; in_ready never looks at a same-cycle pop
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      empty[i]    = (wr_ptr[i] == rd_ptr[i]);
      full[i]     = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                    (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      head[i]     = mem[i][rd_ptr[i][AW-1:0]];
      route[i]    = ROUTE_TABLE[int'(head[i][FLIT_W-1 -: ADDR_W]) * PORT_W +: PORT_W];
      legal[i]    = int'(route[i]) < PORTS;
      in_ready[i] = !full[i] && !reset;
      push[i]     = in_valid[i] && in_ready[i];
      drop[i]     = !empty[i] && !legal[i];
    end
  end

  // Per-output round-robin search starting at rr_ptr; each head targets one output only
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    pop   = drop;
    for (int o = 0; o < PORTS; o++) begin
      winner[o] = 0;
      if (!out_valid[o] || out_ready[o]) begin
        for (int k = 0; k < PORTS; k++) begin
          idx = (int'(rr_ptr[o]) + k) % PORTS;
          if (!grant[o] && !empty[idx] && legal[idx] && (int'(route[idx]) == o)) begin
            grant[o]  = 1'b1;
            winner[o] = idx;
            pop[idx]  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PORTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_flit[i*FLIT_W +: FLIT_W];
    end
  end

  // Output registers: a grant reloads the register, otherwise a consumed flit empties it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= '0;
      out_flit  <= '0;
      for (int o = 0; o < PORTS; o++) rr_ptr[o] <= '0;
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        if (grant[o]) begin
          out_valid[o]                    <= 1'b1;
          out_flit[o*FLIT_W +: FLIT_W]    <= head[winner[o]];
          rr_ptr[o]                       <= PORT_W'((winner[o] + 1) % PORTS);
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < PORTS; i++) acc = acc + 4'(push[i]);
    running_sum = {1'b0, running} + (CNT_W+1)'(acc);
    running_sat = running_sum[CNT_W] ? '1 : running_sum[CNT_W-1:0];
  end

  // The last cycle of each window is folded into the published total
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sampler     <= '0;
      running     <= '0;
      flit_count  <= '0;
      count_valid <= 1'b0;
    end else if (sampler == '1) begin
      flit_count  <= running_sat;
      running     <= '0;
      count_valid <= 1'b1;
      sampler     <= '0;
    end else begin
      running     <= running_sat;
      count_valid <= 1'b0;
      sampler     <= sampler + 1'b1;
    end
  end

endmodule
